// File: rtl/excess3_to_bcd_deframer.sv
// Excess-3 digit stream to packed BCD frame deframer.
// Digits arrive MSD first on a valid/ready link and leave as one word with count/err/ovf.
module excess3_to_bcd_deframer #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_e3,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [CW-1:0]         out_count,
  output logic                  out_err,
  output logic                  out_ovf
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [CW-1:0] MAX_COUNT = CW'(DIGITS);

  state_t              state;
  logic                code_ok;
  logic [3:0]          digit;
  logic [4*DIGITS+3:0] shifted;
  logic                full;
  logic                accept;

  always_comb begin
    code_ok = (in_e3 >= 4'd3) && (in_e3 <= 4'd12);
    digit   = code_ok ? (in_e3 - 4'd3) : 4'd0;
    // Shift through a wider temporary so DIGITS=1 needs no special-case slice.
    shifted = {out_bcd, digit};
    full    = (out_count == MAX_COUNT);
    accept  = in_valid && in_ready && (state != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (full) begin
              out_ovf <= 1'b1;
            end else begin
              out_bcd   <= shifted[4*DIGITS-1:0];
              out_count <= out_count + 1'b1;
            end
            if (!code_ok)
              out_err <= 1'b1;
            if (in_last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
            out_ovf   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_deframer.sv
// Directed bench for excess3_to_bcd_deframer (DIGITS=4): vector table plus corner sequences.
module tb_excess3_to_bcd_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_e3;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic [3:0]  out_count;
  logic        out_err;
  logic        out_ovf;

  int passed = 0;
  int total  = 0;

  excess3_to_bcd_deframer #(.DIGITS(4), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_e3(in_e3), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_count(out_count), .out_err(out_err), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;
    logic [31:0] codes;   // first digit in [3:0], next in [7:4], ...
    logic [15:0] bcd;
    logic [3:0]  cnt;
    logic        err;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Presents one digit and waits (bounded) for the handshake; returns at edge+1.
  task automatic send_digit(input logic [3:0] e3, input logic last);
    bit ok = 0;
    in_valid = 1'b1; in_e3 = e3; in_last = last;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    #1;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0; in_e3 = 4'h0;
  endtask

  task automatic check_frame(input string name, input logic [15:0] bcd, input logic [3:0] cnt,
                             input logic err, input logic ovf);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_bcd"},   {16'd0, out_bcd},   {16'd0, bcd});
    check({name, "_count"}, {28'd0, out_count}, {28'd0, cnt});
    check({name, "_err"},   {31'd0, out_err},   {31'd0, err});
    check({name, "_ovf"},   {31'd0, out_ovf},   {31'd0, ovf});
    check({name, "_inrdy"}, {31'd0, in_ready},  32'd0);
  endtask

  task automatic pop(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_pop_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_pop_inrdy"}, {31'd0, in_ready},  32'd1);
    check({name, "_pop_count"}, {28'd0, out_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] codes;
    vecs[0] = '{"t1_1279",  4, 32'h0000_CA54, 16'h1279, 4'd4, 1'b0, 1'b0};
    vecs[1] = '{"t3_err",   3, 32'h0000_07F3, 16'h0004, 4'd3, 1'b1, 1'b0};
    vecs[2] = '{"t3_clear", 1, 32'h0000_0004, 16'h0001, 4'd1, 1'b0, 1'b0};
    vecs[3] = '{"t4_ovf",   6, 32'h0098_7654, 16'h1234, 4'd4, 1'b0, 1'b1};
    vecs[4] = '{"edges",    2, 32'h0000_003C, 16'h0090, 4'd2, 1'b0, 1'b0};
    vecs[5] = '{"inv_lo_hi",3, 32'h0000_0D50, 16'h0020, 4'd3, 1'b1, 1'b0};
    vecs[6] = '{"single9",  1, 32'h0000_000C, 16'h0009, 4'd1, 1'b0, 1'b0};
    vecs[7] = '{"ovf5",     5, 32'h0007_6543, 16'h0123, 4'd4, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_e3 = 4'h0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inrdy", {31'd0, in_ready},  32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bcd",   {16'd0, out_bcd},   32'd0);
    check("rst_count", {28'd0, out_count}, 32'd0);
    check("rst_flags", {30'd0, out_err, out_ovf}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_inrdy", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      codes = vecs[i].codes;
      for (int d = 0; d < vecs[i].n; d++)
        send_digit(codes[4*d +: 4], d == vecs[i].n - 1);
      check_frame(vecs[i].name, vecs[i].bcd, vecs[i].cnt, vecs[i].err, vecs[i].ovf);
      pop(vecs[i].name);
    end

    // Backpressure: frame must hold steady while out_ready stays low.
    send_digit(4'b0110, 1'b0);
    send_digit(4'b1000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_frame("t2_hold", 16'h0035, 4'd2, 1'b0, 1'b0);
    end
    pop("t2");

    // Gapped in_valid; garbage on in_e3/in_last during gaps must be ignored.
    send_digit(4'b1100, 1'b0);
    in_e3 = 4'hF; in_last = 1'b1; @(posedge clk); #1; in_last = 1'b0;
    send_digit(4'b1011, 1'b0);
    in_e3 = 4'h0; in_last = 1'b1; @(posedge clk); #1; in_last = 1'b0;
    send_digit(4'b1010, 1'b1);
    check_frame("t5_gap", 16'h0987, 4'd3, 1'b0, 1'b0);
    pop("t5");

    // Asynchronous reset mid-frame.
    send_digit(4'b0100, 1'b0);
    send_digit(4'b0101, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check("t6_async_inrdy", {31'd0, in_ready},  32'd0);
    check("t6_async_count", {28'd0, out_count}, 32'd0);
    check("t6_async_bcd",   {16'd0, out_bcd},   32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("t6_post_inrdy", {31'd0, in_ready}, 32'd1);
    send_digit(4'b0011, 1'b1);
    check_frame("t6_new", 16'h0000, 4'd1, 1'b0, 1'b0);
    pop("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
